// File: rtl/fp_sq_seq.sv
// Sequential binary32 squarer: shift-add significand multiply (one partial product per cycle),
// then normalize, round and flag. Constant 25-cycle latency from accepted start to done.
module fp_sq_seq #(
   parameter int unsigned W = 32,
   parameter int unsigned M = 22,
   parameter int unsigned E = 30
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] in1,
   input  logic [2:0]   round_m,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] out,
   output logic         ov,
   output logic         un,
   output logic         inv,
   output logic         inexact
);

   localparam int unsigned FW   = M + 1;
   localparam int unsigned SW   = FW + 1;
   localparam int unsigned PW   = 2 * SW;
   localparam int unsigned EW   = E - M;
   localparam int unsigned ERW  = EW + 2;
   localparam int unsigned CW   = $clog2(SW);
   localparam int unsigned Bias = (1 << (EW - 1)) - 1;
   localparam int unsigned EMax = (1 << EW) - 1;

   localparam logic [2:0] ModeRne = 3'b000;
   localparam logic [2:0] ModeRu  = 3'b011;
   localparam logic [2:0] ModeRna = 3'b100;

   localparam logic [W-1:0] PosInf  = {1'b0, {EW{1'b1}}, {FW{1'b0}}};
   localparam logic [W-1:0] QNan    = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
   localparam logic [W-1:0] MaxNorm = {1'b0, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};

   typedef enum logic [1:0] {StIdle, StMul, StRnd} state_e;
   typedef enum logic [2:0] {SpNone, SpNan, SpInf, SpZero, SpSub} spec_e;

   state_e          state_q, state_d;
   spec_e           spec_q, spec_d, spec_in;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [SW-1:0]   sig_q, sig_d;
   logic [EW-1:0]   exp_q, exp_d;
   logic [2:0]      mode_q, mode_d;
   logic            snan_q, snan_d;
   logic [W-1:0]    out_q, out_d;
   logic            ov_q, ov_d, un_q, un_d, inv_q, inv_d, inx_q, inx_d;
   logic            done_q, done_d;

   logic            n, g, s, inc, carry, uflow, oflow;
   logic [FW-1:0]   frac_raw, frac_rnd;
   logic [ERW-1:0]  er, er_rnd;
   logic [W-1:0]    res_out;
   logic            res_ov, res_un, res_inv, res_inx;

   always_comb begin
      spec_in = SpNone;
      if (in1[E:M+1] == {EW{1'b1}}) begin
         spec_in = (in1[M:0] != '0) ? SpNan : SpInf;
      end else if (in1[E:M+1] == '0) begin
         spec_in = (in1[M:0] != '0) ? SpSub : SpZero;
      end
   end

   // Normalize and round the finished product held in acc_q.
   always_comb begin
      n = acc_q[PW-1];
      if (n) begin
         frac_raw = acc_q[PW-2 -: FW];
         g        = acc_q[PW-2-FW];
         s        = |acc_q[PW-3-FW:0];
      end else begin
         frac_raw = acc_q[PW-3 -: FW];
         g        = acc_q[PW-3-FW];
         s        = |acc_q[PW-4-FW:0];
      end
      er = {1'b0, exp_q, 1'b0} - ERW'(Bias) + {{(ERW-1){1'b0}}, n};
      case (mode_q)
         ModeRne: inc = g & (s | frac_raw[0]);
         ModeRna: inc = g;
         ModeRu:  inc = g | s;
         default: inc = 1'b0;
      endcase
      {carry, frac_rnd} = {1'b0, frac_raw} + {{FW{1'b0}}, inc};
      er_rnd = er + {{(ERW-1){1'b0}}, carry};
      uflow  = er[ERW-1] | (er == '0);
      oflow  = !uflow && (er_rnd >= ERW'(EMax));

      res_out = {1'b0, er_rnd[EW-1:0], frac_rnd};
      res_ov  = 1'b0;
      res_un  = 1'b0;
      res_inv = 1'b0;
      res_inx = g | s;
      unique case (spec_q)
         SpNan: begin
            res_out = QNan;
            res_inv = snan_q;
            res_inx = 1'b0;
         end
         SpInf: begin
            res_out = PosInf;
            res_inx = 1'b0;
         end
         SpZero: begin
            res_out = '0;
            res_inx = 1'b0;
         end
         SpSub: begin
            res_out = '0;
            res_un  = 1'b1;
            res_inx = 1'b1;
         end
         default: begin
            if (uflow) begin
               res_out = '0;
               res_un  = 1'b1;
               res_inx = 1'b1;
            end else if (oflow) begin
               res_ov  = 1'b1;
               res_inx = 1'b1;
               res_out = (mode_q == ModeRne || mode_q == ModeRna || mode_q == ModeRu) ?
                         PosInf : MaxNorm;
            end
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      spec_d  = spec_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sig_d   = sig_q;
      exp_d   = exp_q;
      mode_d  = mode_q;
      snan_d  = snan_q;
      out_d   = out_q;
      ov_d    = ov_q;
      un_d    = un_q;
      inv_d   = inv_q;
      inx_d   = inx_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StMul;
               cnt_d   = '0;
               acc_d   = '0;
               sig_d   = {1'b1, in1[M:0]};
               exp_d   = in1[E:M+1];
               mode_d  = round_m;
               spec_d  = spec_in;
               snan_d  = ~in1[M];
            end
         end
         StMul: begin
            if (sig_q[cnt_q]) begin
               acc_d = acc_q + (PW'(sig_q) << cnt_q);
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SW - 1)) begin
               state_d = StRnd;
            end
         end
         StRnd: begin
            state_d = StIdle;
            done_d  = 1'b1;
            out_d   = res_out;
            ov_d    = res_ov;
            un_d    = res_un;
            inv_d   = res_inv;
            inx_d   = res_inx;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         spec_q  <= SpNone;
         cnt_q   <= '0;
         acc_q   <= '0;
         sig_q   <= '0;
         exp_q   <= '0;
         mode_q  <= '0;
         snan_q  <= 1'b0;
         out_q   <= '0;
         ov_q    <= 1'b0;
         un_q    <= 1'b0;
         inv_q   <= 1'b0;
         inx_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         spec_q  <= spec_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sig_q   <= sig_d;
         exp_q   <= exp_d;
         mode_q  <= mode_d;
         snan_q  <= snan_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         un_q    <= un_d;
         inv_q   <= inv_d;
         inx_q   <= inx_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign out     = out_q;
   assign ov      = ov_q;
   assign un      = un_q;
   assign inv     = inv_q;
   assign inexact = inx_q;

endmodule

// File: tb/tb_fp_sq_seq.sv
// Bench for fp_sq_seq: random and directed operands against an arithmetic squaring model with a
// cycle-level timing model; all outputs are compared on every cycle after reset.
module tb_fp_sq_seq;

   localparam logic [2:0] RNE = 3'b000;
   localparam logic [2:0] RZ  = 3'b001;
   localparam logic [2:0] RD  = 3'b010;
   localparam logic [2:0] RU  = 3'b011;
   localparam logic [2:0] RNA = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] in1;
   logic [2:0]  round_m;
   logic        busy, done, ov, un, inv, inexact;
   logic [31:0] out;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;
   bit          armed  = 1'b0;

   int          m_rem;
   logic        m_done;
   logic [35:0] m_res;
   logic [35:0] m_outs;

   fp_sq_seq #(.W(32), .M(22), .E(30)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in1     (in1),
      .round_m (round_m),
      .busy    (busy),
      .done    (done),
      .out     (out),
      .ov      (ov),
      .un      (un),
      .inv     (inv),
      .inexact (inexact)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result {out, ov, un, inv, inexact} of squaring a under rounding mode rm.
   function automatic logic [35:0] model_sq(input logic [31:0] a, input logic [2:0] rm);
      int unsigned     e, f, frac;
      longint unsigned sig, p;
      int              n, er;
      bit              g, s, inc;
      logic [31:0]     o;
      e = 32'(a[30:23]);
      f = 32'(a[22:0]);
      if (e == 255) return (f != 0) ? {32'h7FC0_0000, 2'b00, ~a[22], 1'b0} : {32'h7F80_0000, 4'b0};
      if (e == 0) return (f == 0) ? 36'h0 : {32'h0, 4'b0101};
      sig  = 64'(f) + 64'd8388608;
      p    = sig * sig;
      n    = (p >= 64'd140737488355328) ? 1 : 0;
      frac = 32'((p >> (23 + n)) % 64'd8388608);
      g    = ((p >> (22 + n)) % 64'd2) != 0;
      s    = (p % (64'd1 << (22 + n))) != 0;
      er   = 2 * int'(e) - 127 + n;
      if (er <= 0) return {32'h0, 4'b0101};
      case (rm)
         RNE:     inc = g && (s || (frac % 2 == 1));
         RNA:     inc = g;
         RU:      inc = g || s;
         default: inc = 1'b0;
      endcase
      frac = frac + 32'(inc);
      if (frac == 8388608) begin
         frac = 0;
         er++;
      end
      if (er >= 255)
         return {(rm == RNE || rm == RNA || rm == RU) ? 32'h7F80_0000 : 32'h7F7F_FFFF, 4'b1001};
      o = {1'b0, er[7:0], frac[22:0]};
      return {o, 3'b000, g || s};
   endfunction

   // Timing model: an accepted start produces done exactly 25 edges later.
   always @(posedge clk) begin
      if (rst) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_outs <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               m_rem <= 25;
               m_res <= model_sq(in1, round_m);
            end
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_done <= 1'b1;
               m_outs <= m_res;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("cycle", 64'({busy, done, out, ov, un, inv, inexact}),
               64'({m_rem != 0, m_done, m_outs}));
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [2:0] rm, input bit junk,
                         output int lat);
      start   = 1'b1;
      in1     = a;
      round_m = rm;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 40) begin
         if (junk) begin
            in1     = $urandom;
            round_m = 3'($urandom_range(7));
            start   = (lat < 20) && ($urandom_range(3) == 0);
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("latency", 64'(lat), 64'd25);
   endtask

   logic [31:0] vec_in  [13];
   logic [2:0]  vec_rm  [13];
   logic [35:0] vec_exp [13];

   initial begin
      int          lat, dones;
      logic [31:0] a;
      logic [7:0]  e;

      vec_in[0]  = 32'h4040_0000; vec_rm[0]  = RNE; vec_exp[0]  = {32'h4110_0000, 4'b0000};
      vec_in[1]  = 32'hC040_0000; vec_rm[1]  = RNE; vec_exp[1]  = {32'h4110_0000, 4'b0000};
      vec_in[2]  = 32'h3F80_0001; vec_rm[2]  = RNE; vec_exp[2]  = {32'h3F80_0002, 4'b0001};
      vec_in[3]  = 32'h3F80_0001; vec_rm[3]  = RU;  vec_exp[3]  = {32'h3F80_0003, 4'b0001};
      vec_in[4]  = 32'h3F80_0001; vec_rm[4]  = RZ;  vec_exp[4]  = {32'h3F80_0002, 4'b0001};
      vec_in[5]  = 32'h5F80_0000; vec_rm[5]  = RNE; vec_exp[5]  = {32'h7F80_0000, 4'b1001};
      vec_in[6]  = 32'h5F80_0000; vec_rm[6]  = RZ;  vec_exp[6]  = {32'h7F7F_FFFF, 4'b1001};
      vec_in[7]  = 32'h1F80_0000; vec_rm[7]  = RNE; vec_exp[7]  = {32'h0000_0000, 4'b0101};
      vec_in[8]  = 32'hFF80_0000; vec_rm[8]  = RNE; vec_exp[8]  = {32'h7F80_0000, 4'b0000};
      vec_in[9]  = 32'h7FA0_0000; vec_rm[9]  = RNE; vec_exp[9]  = {32'h7FC0_0000, 4'b0010};
      vec_in[10] = 32'h7FC0_0000; vec_rm[10] = RNE; vec_exp[10] = {32'h7FC0_0000, 4'b0000};
      vec_in[11] = 32'h8000_0000; vec_rm[11] = RNE; vec_exp[11] = {32'h0000_0000, 4'b0000};
      vec_in[12] = 32'h0000_0001; vec_rm[12] = RD;  vec_exp[12] = {32'h0000_0000, 4'b0101};

      rst     = 1'b1;
      start   = 1'b0;
      in1     = '0;
      round_m = RNE;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      armed = 1'b1;
      check("reset_state", 64'({busy, done, out, ov, un, inv, inexact}), 64'd0);

      // Literal expectations pin both the model and the DUT.
      for (int i = 0; i < 13; i++) begin
         check($sformatf("model_vec%0d", i), 64'(model_sq(vec_in[i], vec_rm[i])),
               64'(vec_exp[i]));
         run_op(vec_in[i], vec_rm[i], 1'b1, lat);
         check($sformatf("dut_vec%0d", i), 64'({out, ov, un, inv, inexact}), 64'(vec_exp[i]));
      end

      // Start issued during the done cycle completes 26 cycles after the previous done.
      run_op(32'h4040_0000, RNE, 1'b0, lat);
      run_op(32'h3F80_0001, RU, 1'b0, lat);
      check("b2b_gap", 64'(lat + 1), 64'd26);
      check("b2b_out", 64'(out), 64'h3F80_0003);

      // Second start five cycles into an op is ignored.
      repeat (2) @(negedge clk);
      start = 1'b1; in1 = 32'h4040_0000; round_m = RNE;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; in1 = 32'h5F80_0000;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("ignored_start_out", 64'({out, ov, un, inv, inexact}), {28'd0, 32'h4110_0000, 4'b0});
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("ignored_start_single_done", 64'(dones), 64'd0);

      // Reset mid-operation aborts without done and clears outputs.
      start = 1'b1; in1 = 32'h3F80_0001; round_m = RU;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_outputs", 64'({busy, done, out, ov, un, inv, inexact}), 64'd0);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(9))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(66, 60));
            3:       e = 8'($urandom_range(194, 188));
            default: e = 8'($urandom_range(254, 1));
         endcase
         a = {1'($urandom_range(1)), e, 23'($urandom)};
         if ($urandom_range(7) == 0) a[22:0] = 23'h7F_FFFF;
         run_op(a, 3'($urandom_range(7)), 1'b1, lat);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fp_sq_seq.md
# fp_sq_seq

Sequential single-precision floating-point squarer (out = in1 × in1), the inverse operation of the FPU's square-root unit. It accepts one IEEE-754 binary32 operand on a start pulse and multiplies the significand by itself with a shift-add datapath, one partial product per cycle. It then normalizes, applies the same five rounding modes and exception flags as the rest of the FPU, and pulses done.

## Interface
- W, 32, total word width
- M, 22, MSB index of stored fraction (fraction = in1[M:0])
- E, 30, MSB index of exponent (exponent = in1[E:M+1])
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- in1  in  W  operand, captured on accepted start
- round_m  in  3  rounding mode (`RNe, `RZ, `RD, `RU, `RNa from special_characters.v), captured on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- out  out  W  result, held until next done
- ov, un, inv, inexact  out  1 each  exception flags, held with out

## Operation
- Clock is clk. Reset is synchronous and active-high on rst.
- FSM states:
  - IDLE: start=1 -> MUL; capture operand and mode, counter=0, accumulator=0.
  - MUL: 24 cycles; each cycle, if multiplier bit[counter]=1, add the shifted significand {1,frac} into the 48-bit accumulator; counter++. After counter=23 -> RND.
  - RND: 1 cycle; register out/flags, done=1 -> IDLE.
- Special-case decode occurs at capture. Special operands still traverse MUL/RND, so latency is constant. In RND, the special result overrides the datapath result.
- Result sign is always 0.
- Special cases:
  - NaN input: out=0x7FC00000; inv=1 if sNaN (fraction MSB=0), else 0; other flags 0.
  - ±Inf: out=0x7F800000, all flags 0.
  - ±0: out=0x00000000, flags 0.
  - Subnormal input: flushed; out=0, un=1, inexact=1.
- Normal path:
  - Product P[47:0] lies in [2^46, 2^48). Normalization bit n=P[47].
  - Fraction = P[45+n:23+n]; guard g = P[22+n]; sticky s = OR of P[21+n:0]; lsb l = fraction bit 0.
  - Biased exponent Er = 2·Ein − 127 + n, computed in 10-bit signed arithmetic.
- Rounding: increment fraction when
  - `RNe: g&(s|l)
  - `RNa: g
  - `RU: g|s
  - `RZ / `RD: never
  - Any other code is treated as `RZ.
- Fraction carry-out sets fraction=0 and Er+1.
- inexact = g|s on the normal path.
- Overflow (Er ≥ 255 after rounding): ov=1, inexact=1. out=0x7F800000 for `RNe/`RNa/`RU; out=0x7F7FFFFF for `RZ/`RD/other.
- Underflow (Er ≤ 0 before rounding): out=+0, un=1, inexact=1. No subnormal outputs.

## Timing
- Reset values: busy=0, done=0, out=0, ov=un=inv=inexact=0; state=IDLE. Reset mid-operation aborts without a done pulse.
- Accepting a start (edge T0):
  - busy=1 from T0 through T25; MUL spans edges T1..T24; RND registers results at T25.
  - done=1 for exactly the cycle after T25; busy=0 in that same cycle. Latency is 25 cycles.
- Throughput and ignored inputs:
  - start while busy=1 is ignored; in1/round_m changes after capture have no effect.
  - start may be high during the done cycle and is accepted at the next edge. Back-to-back issue is one op per 26 cycles.
- out and flags change only at the RND edge, or at reset.

## Test plan
- 0x40400000 (3.0), `RNe -> out=0x41100000 (9.0), all flags 0, done 25 cycles after start; 0xC0400000 gives the same result.
- 0x3F800001 squared -> `RNe: 0x3F800002, inexact=1; `RU: 0x3F800003; `RZ: 0x3F800002.
- 0x5F800000 (2^64) -> `RNe: 0x7F800000, ov=1, inexact=1; `RZ: 0x7F7FFFFF, ov=1.
- 0x1F800000 (2^-64) -> 0x00000000, un=1, inexact=1.
- Specials:
  - 0xFF800000 -> 0x7F800000, flags 0.
  - 0x7FA00000 -> 0x7FC00000, inv=1.
  - 0x7FC00000 -> 0x7FC00000, inv=0.
  - 0x80000000 -> 0x00000000.
- Control:
  - Second start 5 cycles into an op is ignored: single done, result of first operand.
  - rst at cycle 10 of an op: no done, all outputs 0.
  - A new start in the done cycle completes 26 cycles later.
